// File: rtl/systolic_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// systolic_ctrl_pkg
//   Shared definitions for the systolic array sequencing controller:
//   FSM state encoding, the E4M3 zero operand, and the FLUSH/DRAIN length
//   helper that both the controller and its users derive their timing from.
// ----------------------------------------------------------------------------
package systolic_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // E4M3 +0; a zero product leaves every accumulator untouched.
    localparam logic [7:0] E4M3_ZERO = 8'h00;

    // Cycles for a value entering PE(0,0) to reach and settle in PE(n-1,n-1):
    // 2n-2 cycles of skew/pass-through plus the PE datapath latency.
    function automatic int phase_len(input int n, input int pe_lat);
        return 2 * n - 2 + pe_lat;
    endfunction

endpackage

// File: rtl/systolic_ctrl_skew.sv
// ----------------------------------------------------------------------------
// skew_line
//   DEPTH-stage 8-bit register chain used to stagger one edge lane of the
//   systolic array. Lane i uses DEPTH = i+1 so that every lane is registered
//   and lane i trails lane 0 by exactly i cycles.
//
//   Ports:
//     clk  in   clock
//     rst  in   asynchronous active-high reset, clears every stage to 0
//     d    in   8-bit operand entering the chain
//     q    out  8-bit operand leaving the chain, DEPTH cycles later
// ----------------------------------------------------------------------------
module skew_line #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    output logic [7:0] q
);

    logic [7:0] chain [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                chain[k] <= 8'h00;
            end
        end else begin
            chain[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                chain[k] <= chain[k-1];
            end
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// ----------------------------------------------------------------------------
// systolic_ctrl
//   Sequencing controller for an N x N systolic array of E4M3 PEs. Runs one
//   job at a time: clears and flushes the array, streams K operand beats in
//   through skewed edge lanes, drains the array pipeline, then pulses done
//   once every PE's c_out holds its finished dot product.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | waiting for start; k_len captured on start
//   FLUSH    | arr_clear high, zeros pushed, F cycles to purge the array
//   FEED     | in_ready high, each handshake pushes one beat into the skew
//   DRAIN    | zeros pushed for D cycles until the last beat settles
//   DONE     | single-cycle done pulse, array left holding results
//
//   Ports:
//     clk        in   clock
//     rst        in   asynchronous active-high reset
//     start      in   launch a job (sampled in IDLE only)
//     k_len      in   number of beats in the job, captured with start
//     in_valid   in   operand beat valid
//     in_ready   out  operand beat accepted (FEED only)
//     a_vec      in   A operands, lane i -> array row i
//     b_vec      in   B operands, lane j -> array column j
//     arr_a      out  array left edge, lane i drives PE(i,0)
//     arr_b      out  array top edge, lane j drives PE(0,j)
//     arr_clear  out  accumulator clear to every PE
//     busy       out  a job is in progress
//     done       out  one-cycle pulse, all c_out valid
// ----------------------------------------------------------------------------
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int N      = 2,
    parameter int KW     = 5,
    parameter int PE_LAT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [KW-1:0]  k_len,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8*N-1:0] a_vec,
    input  logic [8*N-1:0] b_vec,
    output logic [8*N-1:0] arr_a,
    output logic [8*N-1:0] arr_b,
    output logic           arr_clear,
    output logic           busy,
    output logic           done
);

    // FLUSH and DRAIN share the same length and the same phase counter.
    localparam int PH_CYC = phase_len(N, PE_LAT);
    localparam int PW     = $clog2(PH_CYC + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(PH_CYC - 1);

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] k_cap;
    logic [KW-1:0] beat_cnt;
    logic [PW-1:0] phase_cnt;

    logic          phase_tc;
    logic          phase_load;
    logic          fire;
    logic          last_beat;

    assign phase_tc  = (phase_cnt == '0);
    assign fire      = (state == ST_FEED) && in_valid;
    // Only reachable in FEED, where k_cap is at least 1.
    assign last_beat = fire && (beat_cnt == (k_cap - KW'(1)));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (phase_tc) begin
                    state_nxt = (k_cap == '0) ? ST_DRAIN : ST_FEED;
                end
            end
            ST_FEED: begin
                if (last_beat) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (phase_tc) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Job length capture and beat counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_cap <= '0;
        end else if ((state == ST_IDLE) && start) begin
            k_cap <= k_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if ((state == ST_IDLE) && start) begin
            beat_cnt <= '0;
        end else if (fire && (beat_cnt != k_cap)) begin
            beat_cnt <= beat_cnt + KW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Phase down-counter: loaded on entry to FLUSH or DRAIN, terminal
    // count at zero marks the last cycle of the phase.
    // ------------------------------------------------------------------
    assign phase_load = (state_nxt != state) &&
                        ((state_nxt == ST_FLUSH) || (state_nxt == ST_DRAIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt <= '0;
        end else if (phase_load) begin
            phase_cnt <= PH_LAST;
        end else if (((state == ST_FLUSH) || (state == ST_DRAIN)) && !phase_tc) begin
            phase_cnt <= phase_cnt - PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Edge lanes. Anything other than an accepted beat enters as +0, which
    // covers FLUSH, DRAIN, idle and bubble cycles in FEED alike.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [7:0] a_d;
        logic [7:0] b_d;

        assign a_d = fire ? a_vec[8*i +: 8] : E4M3_ZERO;
        assign b_d = fire ? b_vec[8*i +: 8] : E4M3_ZERO;

        skew_line #(.DEPTH(i + 1)) u_skew_a (
            .clk (clk),
            .rst (rst),
            .d   (a_d),
            .q   (arr_a[8*i +: 8])
        );

        skew_line #(.DEPTH(i + 1)) u_skew_b (
            .clk (clk),
            .rst (rst),
            .d   (b_d),
            .q   (arr_b[8*i +: 8])
        );
    end

    // ------------------------------------------------------------------
    // Status outputs decode straight from state so they drop with reset.
    // ------------------------------------------------------------------
    assign in_ready  = (state == ST_FEED);
    assign arr_clear = (state == ST_FLUSH);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;
    localparam int N      = 2;
    localparam int KW     = 5;
    localparam int PE_LAT = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [KW-1:0]  k_len = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [8*N-1:0] a_vec = '0;
    logic [8*N-1:0] b_vec = '0;
    logic [8*N-1:0] arr_a;
    logic [8*N-1:0] arr_b;
    logic           arr_clear;
    logic           busy;
    logic           done;

    systolic_ctrl #(.N(N), .KW(KW), .PE_LAT(PE_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .arr_a     (arr_a),
        .arr_b     (arr_b),
        .arr_clear (arr_clear),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural PE array (E4M3 in, real accumulate) ----------
    function automatic real e4m3(input logic [7:0] b);
        real r;
        int  e;
        if (b[6:3] == 4'd0) begin
            r = real'(b[2:0]) / 8.0;
            e = -6;
        end else begin
            r = 1.0 + real'(b[2:0]) / 8.0;
            e = int'(b[6:3]) - 7;
        end
        if (e > 0) repeat (e) r = r * 2.0;
        else repeat (-e) r = r / 2.0;
        return b[7] ? -r : r;
    endfunction

    function automatic logic [15:0] bf16(input real v);
        real  m;
        int   e;
        logic s;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        return {s, 8'(e + 127), 7'(int'((m - 1.0) * 128.0))};
    endfunction

    real pa   [N][N];
    real pb   [N][N];
    real acc  [N][N];
    real pipe [N][N][PE_LAT];

    always @(posedge clk or posedge rst) begin
        real ai, bi;
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j]  <= 0.0;
                    pb[i][j]  <= 0.0;
                    acc[i][j] <= 0.0;
                    for (int k = 0; k < PE_LAT; k++) pipe[i][j][k] <= 0.0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ai = (j == 0) ? e4m3(arr_a[8*i +: 8]) : pa[i][(j == 0) ? 0 : j-1];
                    bi = (i == 0) ? e4m3(arr_b[8*j +: 8]) : pb[(i == 0) ? 0 : i-1][j];
                    pa[i][j] <= ai;
                    pb[i][j] <= bi;
                    pipe[i][j][0] <= ai * bi;
                    for (int k = 1; k < PE_LAT; k++) pipe[i][j][k] <= pipe[i][j][k-1];
                    acc[i][j] <= arr_clear ? 0.0 : acc[i][j] + pipe[i][j][PE_LAT-1];
                end
        end
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        int          edge_n;
        logic [63:0] c;
    } exp_t;

    exp_t sb[$];
    int   last_done_edge = -1;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                exp_t e;
                int   de;
                de = cyc + 1;
                last_done_edge = de;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: done at edge %0d with no job outstanding", de);
                end else begin
                    e = sb.pop_front();
                    check("done_edge", de, e.edge_n);
                    @(posedge clk);
                    #1;
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++)
                            check($sformatf("c_out_%0d%0d", i, j), bf16(acc[i][j]),
                                  e.c[63 - 16*(i*N+j) -: 16]);
                end
            end
        end
    end

    // ---------------- per-job trackers ----------------
    int   first_a0, first_a1, first_b0, first_b1;
    int   clr_cnt, rdy_cnt;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            first_a0 = -1; first_a1 = -1; first_b0 = -1; first_b1 = -1;
            clr_cnt = 0; rdy_cnt = 0;
        end
        if (arr_clear) clr_cnt++;
        if (in_ready) rdy_cnt++;
        if (first_a0 < 0 && arr_a[7:0]  != 8'h00) first_a0 = cyc;
        if (first_a1 < 0 && arr_a[15:8] != 8'h00) first_a1 = cyc;
        if (first_b0 < 0 && arr_b[7:0]  != 8'h00) first_b0 = cyc;
        if (first_b1 < 0 && arr_b[15:8] != 8'h00) first_b1 = cyc;
        prev_busy = busy;
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input int k, output int s_edge);
        int n = 0;
        k_len = KW'(k);
        start = 1'b1;
        while (busy && n < 60) begin @(negedge clk); n++; end
        if (n >= 60) begin
            n_vec++; n_err++;
            $display("FAIL start_timeout: busy still %0b after %0d cycles", busy, n);
        end
        @(posedge clk); #1;
        s_edge = cyc;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                             input int gap, output int t_edge);
        int n = 0;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        a_vec = a;
        b_vec = b;
        while (!in_ready && n < 60) begin @(negedge clk); n++; end
        if (n >= 60) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: in_ready %0b after %0d cycles", in_ready, n);
        end
        @(posedge clk); #1;
        t_edge = cyc;
        in_valid = 1'b0;
        a_vec = '0;
        b_vec = '0;
    endtask

    // Expected done edge: last handshake + 2N-1+PE_LAT, or start + F + D + 1.
    task automatic run_job(input int k, input logic [15:0] a, input logic [15:0] b,
                           input int gap, input logic poke, input logic [63:0] cexp,
                           output int s_edge, output int t_first);
        int   t;
        exp_t e;
        do_start(k, s_edge);
        t_first = -1;
        if (k == 0) begin
            e.edge_n = s_edge + 2*(2*N - 2 + PE_LAT) + 1;
            e.c = cexp;
            sb.push_back(e);
        end else begin
            for (int bt = 0; bt < k; bt++) begin
                send_beat(a, b, gap, t);
                if (bt == 0) t_first = t;
                if (bt == k - 1) begin
                    e.edge_n = t + 2*N - 1 + PE_LAT;
                    e.c = cexp;
                    sb.push_back(e);
                end
                if (poke) begin
                    // start with a different length while busy must be ignored
                    k_len = '0;
                    start = 1'b1;
                    if (bt == k - 1) begin
                        @(negedge clk); @(negedge clk);
                        start = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 80) begin @(negedge clk); n++; end
        if (n >= 80) begin
            n_vec++; n_err++;
            $display("FAIL idle_timeout: busy %0b pending %0d", busy, sb.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int s, t1, s2;
        repeat (3) @(negedge clk);
        check("rst_arr_a", arr_a, 0);
        check("rst_arr_b", arr_b, 0);
        check("rst_arr_clear", arr_clear, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single beat, 1.0 x 1.0
        run_job(1, 16'h3838, 16'h3838, 0, 1'b0, {4{16'h3F80}}, s, t1);
        wait_idle();
        check("clear_cycles_k1", clr_cnt, 6);

        // three beats with 2-cycle gaps; starts poked during FEED and DRAIN
        run_job(3, 16'h4038, 16'h3840, 2, 1'b1,
                {16'h40C0, 16'h4040, 16'h4140, 16'h40C0}, s, t1);
        wait_idle();
        check("skew_a0", first_a0, t1);
        check("skew_a1", first_a1, t1 + 1);
        check("skew_b0", first_b0, t1);
        check("skew_b1", first_b1, t1 + 1);
        repeat (3) @(negedge clk);
        check("idle_after_poke", busy, 0);

        // same operands, no gaps
        run_job(3, 16'h4038, 16'h3840, 0, 1'b0,
                {16'h40C0, 16'h4040, 16'h4140, 16'h40C0}, s, t1);
        wait_idle();

        // empty job
        run_job(0, 16'h0000, 16'h0000, 0, 1'b0, 64'h0, s, t1);
        wait_idle();
        check("clear_cycles_k0", clr_cnt, 6);
        check("ready_cycles_k0", rdy_cnt, 0);

        // reset in the middle of FEED
        do_start(3, s);
        send_beat(16'h4040, 16'h4040, 0, t1);
        @(negedge clk);
        check("ready_before_rst", in_ready, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_busy", busy, 0);
        check("rst_async_ready", in_ready, 0);
        check("rst_async_arr_a", arr_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_job(2, 16'h3838, 16'h4040, 1, 1'b0, {4{16'h4080}}, s, t1);
        wait_idle();

        // back-to-back jobs, second must not see the first's products
        run_job(1, 16'h4040, 16'h4040, 0, 1'b0, {4{16'h4080}}, s, t1);
        run_job(1, 16'h3838, 16'h3838, 0, 1'b0, {4{16'h3F80}}, s2, t1);
        check("b2b_start_edge", s2, last_done_edge + 1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
